// File: rtl/cpu_bus_pkg.sv
// Shared constants and FSM state type for the CPU data-memory responder.
package cpu_bus_pkg;

    localparam int unsigned WordWidth     = 32;
    localparam int unsigned ByteWidth     = 8;
    localparam int unsigned ByteLanes     = WordWidth / ByteWidth;
    localparam int unsigned WaitStatesMax = 15;
    localparam int unsigned CntWidth      = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data bus between a requester (master) and the data memory responder (slave).
interface data_mem_responder_if;
    import cpu_bus_pkg::*;

    logic                 req;
    logic                 read_n_write;
    logic [WordWidth-1:0] address;
    logic [WordWidth-1:0] d;
    logic [ByteLanes-1:0] be;
    logic                 ready;
    logic [WordWidth-1:0] q;
    logic                 err;

    modport master (
        output req, read_n_write, address, d, be,
        input  ready, q, err
    );

    modport slave (
        input  req, read_n_write, address, d, be,
        output ready, q, err
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word memory with per-byte write enables; contents are not reset.
module dmem_ram
    import cpu_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DEPTH_LOG2-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned NumBytes = DATA_WIDTH / ByteWidth;

    logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (be[i]) begin
                    mem[addr][ByteWidth*i +: ByteWidth] <= wdata[ByteWidth*i +: ByteWidth];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data memory responder: accepts one access in idle, answers with a one-cycle ready.
// Optional macro DMEM_BOUNDS_CHECK_EN faults accesses whose upper address bits are nonzero.
module data_mem_responder
    import cpu_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    if (WAIT_STATES > WaitStatesMax) begin : gen_ws_range
        $error("WAIT_STATES out of range");
    end

    localparam logic [CntWidth-1:0] CntInit =
        CntWidth'((WAIT_STATES == 0) ? 32'd0 : WAIT_STATES - 32'd1);

    state_e                  state_q;
    logic [CntWidth-1:0]     cnt_q;
    logic                    rnw_q;
    logic                    fault_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DATA_WIDTH-1:0]   d_q;
    logic [DATA_WIDTH/8-1:0] be_q;
    logic                    ready_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   q_q;

    logic                    addr_oob;
    logic                    fault_in;
    logic                    ram_we;
    logic [DEPTH_LOG2-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_rdata;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign addr_oob = |bus.address[WordWidth-1:DEPTH_LOG2+2];
`else
    logic unused_addr_hi;
    assign addr_oob       = 1'b0;
    assign unused_addr_hi = ^bus.address[WordWidth-1:DEPTH_LOG2+2];
`endif

    assign fault_in = (|bus.address[1:0]) | addr_oob;

    // Idle reads the live bus address so load data is ready by the response edge even with
    // zero wait states; afterwards the latched index holds the port for the commit.
    assign ram_addr = (state_q == StIdle) ? bus.address[DEPTH_LOG2+1:2] : idx_q;
    assign ram_we   = (state_q == StResp) && !rnw_q && !fault_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            q_q     <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            q_q     <= '0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        rnw_q   <= bus.read_n_write;
                        idx_q   <= bus.address[DEPTH_LOG2+1:2];
                        d_q     <= bus.d;
                        be_q    <= bus.be;
                        fault_q <= fault_in;
                        cnt_q   <= CntInit;
                        state_q <= (WAIT_STATES == 0) ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    ready_q <= 1'b1;
                    err_q   <= fault_q;
                    q_q     <= (rnw_q && !fault_q) ? ram_rdata : '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.q     = q_q;

    dmem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be_q),
        .addr  (ram_addr),
        .wdata (d_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with one wait state, one with none, sharing clock and reset.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if bus1 ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(
        .DATA_WIDTH  (32),
        .DEPTH_LOG2  (10),
        .WAIT_STATES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    data_mem_responder #(
        .DATA_WIDTH  (32),
        .DEPTH_LOG2  (10),
        .WAIT_STATES (0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int n_vec = 0;
    int n_bad = 0;

    // fast=1 selects the zero-wait-state instance
    task automatic drive(input bit fast, input logic rq, input logic rnw,
                         input logic [31:0] a, input logic [31:0] dd, input logic [3:0] b);
        if (fast) begin
            bus0.req = rq; bus0.read_n_write = rnw; bus0.address = a; bus0.d = dd; bus0.be = b;
        end else begin
            bus1.req = rq; bus1.read_n_write = rnw; bus1.address = a; bus1.d = dd; bus1.be = b;
        end
    endtask

    task automatic access(input bit fast, input logic rnw, input logic [31:0] a,
                          input logic [31:0] dd, input logic [3:0] b,
                          output int lat, output logic [31:0] qv, output logic ev);
        @(posedge clk);
        #1 drive(fast, 1'b1, rnw, a, dd, b);
        @(posedge clk);
        #1 drive(fast, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        lat = -1;
        qv  = '0;
        ev  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (lat < 0) begin
                @(posedge clk);
                @(negedge clk);
                if ((fast ? bus0.ready : bus1.ready) === 1'b1) begin
                    lat = k;
                    qv  = fast ? bus0.q : bus1.q;
                    ev  = fast ? bus0.err : bus1.err;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus1.ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready1: got %b, want 0", bus1.ready); end
        n_vec++; if (bus1.err !== 1'b0) begin n_bad++; $display("FAIL rst_err1: got %b, want 0", bus1.err); end
        n_vec++; if (bus1.q !== 32'h0) begin n_bad++; $display("FAIL rst_q1: got %h, want 0", bus1.q); end
        n_vec++; if (bus0.ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready0: got %b, want 0", bus0.ready); end
        n_vec++; if (bus0.err !== 1'b0) begin n_bad++; $display("FAIL rst_err0: got %b, want 0", bus0.err); end
        n_vec++; if (bus0.q !== 32'h0) begin n_bad++; $display("FAIL rst_q0: got %h, want 0", bus0.q); end
        // req coinciding with reset must be dropped
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF);
        drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus1.ready !== 1'b0 || bus0.ready !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_req_ignored: got ready %b/%b, want 0/0", bus1.ready, bus0.ready);
            end
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] qv; logic ev;
        access(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, lat, qv, ev);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL st_latency: got %0d, want 2", lat); end
        n_vec++; if (ev !== 1'b0) begin n_bad++; $display("FAIL st_err: got %b, want 0", ev); end
        access(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, lat, qv, ev);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL ld_latency: got %0d, want 2", lat); end
        n_vec++; if (qv !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_q: got %h, want deadbeef", qv); end
        n_vec++; if (ev !== 1'b0) begin n_bad++; $display("FAIL ld_err: got %b, want 0", ev); end
    endtask

    task automatic test_byte_enable();
        int lat; logic [31:0] qv; logic ev;
        access(1'b0, 1'b0, 32'h10, 32'h000000AA, 4'b0001, lat, qv, ev);
        access(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, lat, qv, ev);
        n_vec++; if (qv !== 32'hDEADBEAA) begin n_bad++; $display("FAIL be_lane0: got %h, want deadbeaa", qv); end
        access(1'b0, 1'b0, 32'h10, 32'h12345678, 4'b0000, lat, qv, ev);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL be_none_ready: got %0d, want 2", lat); end
        n_vec++; if (ev !== 1'b0) begin n_bad++; $display("FAIL be_none_err: got %b, want 0", ev); end
        access(1'b0, 1'b1, 32'h10, 32'h0, 4'hF, lat, qv, ev);
        n_vec++; if (qv !== 32'hDEADBEAA) begin n_bad++; $display("FAIL be_none_nowrite: got %h, want deadbeaa", qv); end
        access(1'b0, 1'b0, 32'h10, 32'h55660000, 4'b1100, lat, qv, ev);
        access(1'b0, 1'b1, 32'h10, 32'h0, 4'b0001, lat, qv, ev);
        n_vec++; if (qv !== 32'h5566BEAA) begin n_bad++; $display("FAIL be_upper: got %h, want 5566beaa", qv); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] qv; logic ev;
        access(1'b0, 1'b0, 32'h13, 32'hFFFFFFFF, 4'hF, lat, qv, ev);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL mis_st_ready: got %0d, want 2", lat); end
        n_vec++; if (ev !== 1'b1) begin n_bad++; $display("FAIL mis_st_err: got %b, want 1", ev); end
        access(1'b0, 1'b1, 32'h10, 32'h0, 4'hF, lat, qv, ev);
        n_vec++; if (qv !== 32'h5566BEAA) begin n_bad++; $display("FAIL mis_nowrite: got %h, want 5566beaa", qv); end
        access(1'b0, 1'b1, 32'h11, 32'h0, 4'hF, lat, qv, ev);
        n_vec++; if (ev !== 1'b1) begin n_bad++; $display("FAIL mis_ld_err: got %b, want 1", ev); end
        n_vec++; if (qv !== 32'h0) begin n_bad++; $display("FAIL mis_ld_q: got %h, want 0", qv); end
    endtask

    task automatic test_bounds();
        int lat; logic [31:0] qv; logic ev;
        access(1'b0, 1'b0, 32'h0, 32'h01234567, 4'hF, lat, qv, ev);
        access(1'b0, 1'b1, 32'h0000_1000, 32'h0, 4'hF, lat, qv, ev);
`ifdef DMEM_BOUNDS_CHECK_EN
        n_vec++; if (ev !== 1'b1) begin n_bad++; $display("FAIL oob_err: got %b, want 1", ev); end
        n_vec++; if (qv !== 32'h0) begin n_bad++; $display("FAIL oob_q: got %h, want 0", qv); end
`else
        n_vec++; if (ev !== 1'b0) begin n_bad++; $display("FAIL wrap_err: got %b, want 0", ev); end
        n_vec++; if (qv !== 32'h01234567) begin n_bad++; $display("FAIL wrap_q: got %h, want 01234567", qv); end
`endif
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] qv; logic ev; bit seen;
        access(1'b0, 1'b0, 32'h20, 32'h0BADF00D, 4'hF, lat, qv, ev);
        for (int phase = 0; phase < 2; phase++) begin
            @(posedge clk);
            #1 drive(1'b0, 1'b1, 1'b0, 32'h20, (phase == 0) ? 32'hFFFFFFFF : 32'hEEEEEEEE, 4'hF);
            @(posedge clk);
            #1 drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
            if (phase == 1) begin
                @(posedge clk);
                #1;
            end
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (bus1.ready !== 1'b0) seen = 1'b1;
            end
            n_vec++;
            if (seen) begin n_bad++; $display("FAIL abort_ready_p%0d: got pulse, want none", phase); end
        end
        access(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, lat, qv, ev);
        n_vec++; if (qv !== 32'h0BADF00D) begin n_bad++; $display("FAIL abort_nowrite: got %h, want 0badf00d", qv); end
    endtask

    task automatic test_ignore_busy();
        int lat; logic [31:0] qv; logic ev;
        access(1'b0, 1'b0, 32'h34, 32'h0, 4'hF, lat, qv, ev);
        @(posedge clk);
        #1 drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h00000077, 4'hF);
        @(posedge clk);
        #1 drive(1'b0, 1'b1, 1'b0, 32'h34, 32'h99999999, 4'hF);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus1.ready !== 1'b1) begin n_bad++; $display("FAIL busy_ready: got %b, want 1", bus1.ready); end
        access(1'b0, 1'b1, 32'h34, 32'h0, 4'hF, lat, qv, ev);
        n_vec++; if (qv !== 32'h0) begin n_bad++; $display("FAIL busy_ignored: got %h, want 0", qv); end
        access(1'b0, 1'b1, 32'h30, 32'h0, 4'hF, lat, qv, ev);
        n_vec++; if (qv !== 32'h77) begin n_bad++; $display("FAIL busy_first: got %h, want 77", qv); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] qv; logic ev;
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h00000042, 4'hF);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk);
            if (cyc == 6) #1 drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
            @(negedge clk);
            n_vec++;
            if (bus0.ready !== ((cyc % 2) == 0)) begin
                n_bad++;
                $display("FAIL b2b_cycle%0d: got ready %b, want %b", cyc, bus0.ready, (cyc % 2) == 0);
            end
        end
        access(1'b1, 1'b1, 32'h40, 32'h0, 4'hF, lat, qv, ev);
        n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL ws0_latency: got %0d, want 1", lat); end
        n_vec++; if (qv !== 32'h42) begin n_bad++; $display("FAIL ws0_q: got %h, want 42", qv); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_misaligned();
        test_bounds();
        test_reset_abort();
        test_ignore_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
